// File: rtl/ate_ddr3_pkg.sv
// Shared types and constants for the DDR3 block-transfer scheduler.
package ate_ddr3_pkg;

    localparam int DDR3_AW = 26;
    localparam int BUF_AW  = 12;
    localparam int WORDS_W = 16;

    localparam logic DIR_WR = 1'b0;
    localparam logic DIR_RD = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_CHECK   = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    // Mover moves 64-bit DDR3 beats, so a request must be a nonzero even word count.
    function automatic logic req_len_bad(input logic [WORDS_W-1:0] words);
        return (words == 16'd0) || words[0];
    endfunction

endpackage

// File: rtl/ate_ddr3_chunk_calc.sv
// Chunk sizing and next-chunk address arithmetic for the transfer scheduler.
module ate_ddr3_chunk_calc
    import ate_ddr3_pkg::*;
#(
    parameter int MAX_CHUNK = 2048
) (
    input  logic [WORDS_W-1:0] remaining,
    input  logic [DDR3_AW-1:0] ddr3_addr,
    input  logic [BUF_AW-1:0]  buf_addr,
    output logic [BUF_AW-1:0]  chunk,
    output logic [DDR3_AW-1:0] ddr3_next,
    output logic [BUF_AW-1:0]  buf_next
);

    localparam logic [WORDS_W-1:0] MAX_W = WORDS_W'(MAX_CHUNK);

    // Chunk is the smaller of what is left and what the mover accepts.
    always_comb begin
        chunk = 12'd0;
        if (remaining > MAX_W) begin
            chunk = MAX_W[BUF_AW-1:0];
        end else begin
            chunk = remaining[BUF_AW-1:0];
        end
    end

    // DDR3 addresses count 2-word beats; both addresses wrap silently.
    assign ddr3_next = ddr3_addr + {14'd0, chunk[BUF_AW-1:1]};
    assign buf_next  = buf_addr + chunk;

endmodule

// File: rtl/ate_ddr3_xfer_sched.sv
// Splits one host block-transfer request into mover-sized chunks, with go/bsy
// handshaking, fault retry and a single completion report per request.
module ate_ddr3_xfer_sched
    import ate_ddr3_pkg::*;
#(
    parameter int MAX_CHUNK  = 2048,
    parameter int MAX_RETRY  = 2,
    parameter int GO_TIMEOUT = 255
) (
    input  logic               ui_clk,
    input  logic               rst_n,
    input  logic               i_app_phy_init_done,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic               i_req_dir,
    input  logic [WORDS_W-1:0] i_req_words,
    input  logic [DDR3_AW-1:0] i_req_ddr3_addr,
    input  logic [BUF_AW-1:0]  i_req_buf_addr,
    output logic               o_done,
    output logic               o_done_err,
    output logic [WORDS_W-1:0] o_done_words,
    output logic               o_busy,
    output logic               o_ibuf_go,
    output logic               o_obuf_go,
    input  logic               i_ibuf_bsy,
    input  logic               i_obuf_bsy,
    input  logic               i_ibuf_ddr3_fault,
    input  logic               i_obuf_ddr3_fault,
    output logic [BUF_AW-1:0]  o_ibuf_count,
    output logic [BUF_AW-1:0]  o_obuf_count,
    output logic [BUF_AW-1:0]  o_ibuf_start_addrb,
    output logic [BUF_AW-1:0]  o_obuf_start_addra,
    output logic [DDR3_AW-1:0] o_ddr3_addra,
    output logic [DDR3_AW-1:0] o_ddr3_addrb
);

    localparam int TO_W = $clog2(GO_TIMEOUT + 1);
    localparam int RW   = $clog2(MAX_RETRY + 2);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(GO_TIMEOUT - 1);
    localparam logic [RW-1:0]   RETRY_MAX = RW'(MAX_RETRY);

    state_e               state_r;
    logic                 ready_r, busy_r, done_r, done_err_r, err_r, go_r, dir_r;
    logic [WORDS_W-1:0]   done_words_r, rem_r, acc_r;
    logic [DDR3_AW-1:0]   ddr_r;
    logic [BUF_AW-1:0]    buf_r, cnt_r;
    logic [TO_W-1:0]      to_r;
    logic [RW-1:0]        retry_r;

    logic [BUF_AW-1:0]    chunk_s, buf_next_s;
    logic [DDR3_AW-1:0]   ddr3_next_s;
    logic                 bsy_s, fault_s;

    ate_ddr3_chunk_calc #(.MAX_CHUNK(MAX_CHUNK)) u_chunk_calc (
        .remaining (rem_r),
        .ddr3_addr (ddr_r),
        .buf_addr  (buf_r),
        .chunk     (chunk_s),
        .ddr3_next (ddr3_next_s),
        .buf_next  (buf_next_s)
    );

    assign bsy_s   = (dir_r == DIR_RD) ? i_obuf_bsy        : i_ibuf_bsy;
    assign fault_s = (dir_r == DIR_RD) ? i_obuf_ddr3_fault : i_ibuf_ddr3_fault;

    // Request sequencing: accept, launch chunks, track bsy, retry faults, report.
    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            ready_r      <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            done_err_r   <= 1'b0;
            done_words_r <= 16'd0;
            err_r        <= 1'b0;
            go_r         <= 1'b0;
            dir_r        <= 1'b0;
            rem_r        <= 16'd0;
            acc_r        <= 16'd0;
            ddr_r        <= 26'd0;
            buf_r        <= 12'd0;
            cnt_r        <= 12'd0;
            to_r         <= '0;
            retry_r      <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r       <= 1'b0;
                    done_err_r   <= 1'b0;
                    done_words_r <= 16'd0;
                    busy_r       <= 1'b0;
                    if (i_req_valid && ready_r) begin
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                        dir_r   <= i_req_dir;
                        rem_r   <= i_req_words;
                        acc_r   <= 16'd0;
                        ddr_r   <= i_req_ddr3_addr;
                        buf_r   <= i_req_buf_addr;
                        retry_r <= '0;
                        if (req_len_bad(i_req_words)) begin
                            err_r   <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            err_r   <= 1'b0;
                            state_r <= ST_LAUNCH;
                        end
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    if (i_app_phy_init_done) begin
                        cnt_r   <= chunk_s;
                        go_r    <= 1'b1;
                        to_r    <= '0;
                        state_r <= ST_WAIT_HI;
                    end
                end
                ST_WAIT_HI: begin
                    if (bsy_s) begin
                        go_r    <= 1'b0;
                        state_r <= ST_WAIT_LO;
                    end else if (to_r == TO_LAST) begin
                        go_r    <= 1'b0;
                        err_r   <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        to_r <= to_r + TO_W'(1);
                    end
                end
                ST_WAIT_LO: begin
                    if (!bsy_s) begin
                        state_r <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (fault_s) begin
                        if (retry_r < RETRY_MAX) begin
                            retry_r <= retry_r + RW'(1);
                            state_r <= ST_LAUNCH;
                        end else begin
                            err_r   <= 1'b1;
                            state_r <= ST_DONE;
                        end
                    end else begin
                        acc_r   <= acc_r + {4'd0, chunk_s};
                        rem_r   <= rem_r - {4'd0, chunk_s};
                        retry_r <= '0;
                        ddr_r   <= ddr3_next_s;
                        buf_r   <= buf_next_s;
                        if (rem_r == {4'd0, chunk_s}) begin
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_LAUNCH;
                        end
                    end
                end
                ST_DONE: begin
                    done_r       <= 1'b1;
                    done_err_r   <= err_r;
                    done_words_r <= acc_r;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    go_r    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Only the mover selected by the request direction sees go and chunk fields.
    assign o_req_ready        = ready_r;
    assign o_busy             = busy_r;
    assign o_done             = done_r;
    assign o_done_err         = done_err_r;
    assign o_done_words       = done_words_r;
    assign o_ibuf_go          = go_r && (dir_r == DIR_WR);
    assign o_obuf_go          = go_r && (dir_r == DIR_RD);
    assign o_ibuf_count       = (dir_r == DIR_WR) ? cnt_r : 12'd0;
    assign o_obuf_count       = (dir_r == DIR_RD) ? cnt_r : 12'd0;
    assign o_ibuf_start_addrb = (dir_r == DIR_WR) ? buf_r : 12'd0;
    assign o_obuf_start_addra = (dir_r == DIR_RD) ? buf_r : 12'd0;
    assign o_ddr3_addra       = (dir_r == DIR_WR) ? ddr_r : 26'd0;
    assign o_ddr3_addrb       = (dir_r == DIR_RD) ? ddr_r : 26'd0;

endmodule
